// File: rtl/line_buffer_col_feeder.sv
// line_buffer_col_feeder
// Producer side of the KxK window register array. Accepts a raster pixel
// stream and keeps KER_SIZE-1 previous rows in row storage. For every pixel
// accepted in the streaming phase it emits one KER_SIZE-tall column plus the
// slot/fill pointers the window array consumes. win_valid marks the cycle in
// which the array output holds a complete window.
module line_buffer_col_feeder #(
    parameter int KER_SIZE = 3,
    parameter int BITWIDTH = 8,
    parameter int AW       = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [AW:0]                  img_w,
    input  logic [15:0]                  img_h,
    input  logic                         in_valid,
    input  logic [BITWIDTH-1:0]          in_data,
    output logic                         in_ready,
    output logic [BITWIDTH*KER_SIZE-1:0] col_out,
    output logic [2:0]                   col_ptr,
    output logic [2:0]                   init_col_ptr,
    output logic                         win_valid,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         cfg_err
);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    localparam logic [AW:0]   W_MIN         = (AW+1)'(KER_SIZE);
    localparam logic [AW:0]   W_MAX         = (AW+1)'(1 << AW);
    localparam logic [AW:0]   W_ONE         = (AW+1)'(1);
    localparam logic [15:0]   H_MIN         = 16'(KER_SIZE);
    localparam logic [15:0]   FILL_LAST_ROW = 16'(KER_SIZE - 2);
    localparam logic [AW-1:0] X_WIN         = AW'(KER_SIZE - 1);
    localparam logic [AW-1:0] X_ONE         = AW'(1);
    localparam logic [2:0]    SLOT_LAST     = 3'(KER_SIZE - 1);
    localparam logic [2:0]    PTR_IDLE      = 3'b111;

    state_t state_q;
    state_t state_d;

    logic [AW:0]   img_w_r;
    logic [15:0]   img_h_r;
    logic [AW-1:0] col_x;
    logic [15:0]   row_y;
    logic [2:0]    cslot;

    // Row storage: lb[0] is the oldest row, lb[KER_SIZE-2] the most recent one.
    logic [KER_SIZE-2:0][(1<<AW)-1:0][BITWIDTH-1:0] lb;

    logic [BITWIDTH*KER_SIZE-1:0] col_next;
    logic cfg_ok;
    logic accept;
    logic emit;
    logic last_col;
    logic frame_go;
    logic win_pre;

    assign cfg_ok     = (img_w >= W_MIN) && (img_w <= W_MAX) && (img_h >= H_MIN);
    assign in_ready   = (state_q == FILL) || (state_q == STREAM);
    assign busy       = in_ready;
    assign frame_done = (state_q == DONE);
    assign accept     = in_valid && in_ready;
    assign emit       = accept && (state_q == STREAM);
    assign last_col   = ({1'b0, col_x} == (img_w_r - W_ONE));
    assign frame_go   = (state_q == IDLE) && start && cfg_ok;

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: fill K-1 rows, stream the rest, one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_go) state_d = FILL;
            FILL:    if (accept && last_col && (row_y == FILL_LAST_ROW)) state_d = STREAM;
            STREAM:  if (accept && last_col && (row_y == (img_h_r - 16'd1))) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame configuration and raster position counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            img_w_r <= '0;
            img_h_r <= '0;
            col_x   <= '0;
            row_y   <= '0;
            cslot   <= '0;
        end else if (frame_go) begin
            img_w_r <= img_w;
            img_h_r <= img_h;
            col_x   <= '0;
            row_y   <= '0;
            cslot   <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_x <= '0;
                row_y <= row_y + 16'd1;
                cslot <= '0;
            end else begin
                col_x <= col_x + X_ONE;
                cslot <= (cslot == SLOT_LAST) ? 3'd0 : cslot + 3'd1;
            end
        end
    end

    // Column assembled from the pre-update row storage with the live pixel on top.
    always_comb begin
        col_next = '0;
        for (int k = 0; k < KER_SIZE - 1; k++) begin
            col_next[BITWIDTH*k +: BITWIDTH] = lb[k][col_x];
        end
        col_next[BITWIDTH*(KER_SIZE-1) +: BITWIDTH] = in_data;
    end

    // Row storage shift at the accepted column: each row moves one step older.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lb <= '0;
        end else if (accept) begin
            for (int j = 0; j < KER_SIZE - 2; j++) begin
                lb[j][col_x] <= lb[j+1][col_x];
            end
            lb[KER_SIZE-2][col_x] <= in_data;
        end
    end

    // Registered column emit, pointers, window flag pipeline and config error pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_out      <= '0;
            col_ptr      <= PTR_IDLE;
            init_col_ptr <= PTR_IDLE;
            win_pre      <= 1'b0;
            win_valid    <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            cfg_err   <= (state_q == IDLE) && start && !cfg_ok;
            win_pre   <= emit && (col_x >= X_WIN);
            win_valid <= win_pre;
            if (emit) begin
                col_out      <= col_next;
                col_ptr      <= cslot;
                init_col_ptr <= (col_x >= X_WIN) ? SLOT_LAST : col_x[2:0];
            end else begin
                col_ptr      <= PTR_IDLE;
                init_col_ptr <= PTR_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_col_feeder.sv
// tb_line_buffer_col_feeder
// Directed bench for line_buffer_col_feeder: a K=3 instance for the small
// frames, reset and start-filtering scenarios, and a K=5 instance for the
// full-width (2^AW) frame.
module tb_line_buffer_col_feeder;

    localparam int BW = 8;
    localparam int AW = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    always #5 clk = ~clk;

    logic            start3    = 1'b0;
    logic [AW:0]     img_w3    = '0;
    logic [15:0]     img_h3    = '0;
    logic            in_valid3 = 1'b0;
    logic [BW-1:0]   in_data3  = '0;
    logic            in_ready3;
    logic [3*BW-1:0] col_out3;
    logic [2:0]      col_ptr3;
    logic [2:0]      init3;
    logic            win3;
    logic            busy3;
    logic            done3;
    logic            err3;

    logic            start5    = 1'b0;
    logic [AW:0]     img_w5    = '0;
    logic [15:0]     img_h5    = '0;
    logic            in_valid5 = 1'b0;
    logic [BW-1:0]   in_data5  = '0;
    logic            in_ready5;
    logic [5*BW-1:0] col_out5;
    logic [2:0]      col_ptr5;
    logic [2:0]      init5;
    logic            win5;
    logic            busy5;
    logic            done5;
    logic            err5;

    line_buffer_col_feeder #(.KER_SIZE(3), .BITWIDTH(BW), .AW(AW)) dut3 (
        .clk(clk), .rstn(rstn), .start(start3), .img_w(img_w3), .img_h(img_h3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .col_out(col_out3), .col_ptr(col_ptr3), .init_col_ptr(init3),
        .win_valid(win3), .busy(busy3), .frame_done(done3), .cfg_err(err3)
    );

    line_buffer_col_feeder #(.KER_SIZE(5), .BITWIDTH(BW), .AW(AW)) dut5 (
        .clk(clk), .rstn(rstn), .start(start5), .img_w(img_w5), .img_h(img_h5),
        .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
        .col_out(col_out5), .col_ptr(col_ptr5), .init_col_ptr(init5),
        .win_valid(win5), .busy(busy5), .frame_done(done5), .cfg_err(err5)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int win_cnt3   = 0;
    int done_cnt3  = 0;
    int first_win3 = -1;
    int win_cnt5   = 0;
    logic [2:0]      q3_ptr[$];
    logic [2:0]      q3_init[$];
    logic [3*BW-1:0] q3_col[$];
    logic [2:0]      q5_ptr[$];
    logic [2:0]      q5_init[$];
    logic [5*BW-1:0] q5_col[$];

    // Free-running cycle counter used to time window pulses against acceptances.
    always @(posedge clk) cyc <= cyc + 1;

    // Record emitted columns, window pulses and frame_done pulses mid-cycle.
    always @(negedge clk) begin
        if (win3) begin
            win_cnt3++;
            if (first_win3 < 0) first_win3 = cyc;
        end
        if (done3) done_cnt3++;
        if (col_ptr3 != 3'b111) begin
            q3_ptr.push_back(col_ptr3);
            q3_init.push_back(init3);
            q3_col.push_back(col_out3);
        end
        if (win5) win_cnt5++;
        if (col_ptr5 != 3'b111) begin
            q5_ptr.push_back(col_ptr5);
            q5_init.push_back(init5);
            q5_col.push_back(col_out5);
        end
    end

    task automatic clear_mon();
        win_cnt3   = 0;
        done_cnt3  = 0;
        first_win3 = -1;
        win_cnt5   = 0;
        q3_ptr.delete();
        q3_init.delete();
        q3_col.delete();
        q5_ptr.delete();
        q5_init.delete();
        q5_col.delete();
    endtask

    // Drives one K=3 frame of raster pixels base, base+1, ... with optional gaps.
    task automatic run_frame3(input int w, input int h, input int base, input int gap,
                              input int mark, output int mark_cyc, output logic done_seen);
        mark_cyc  = -1;
        done_seen = 1'b0;
        @(posedge clk); #1;
        img_w3 = (AW+1)'(w);
        img_h3 = 16'(h);
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int i = 0; i < w * h; i++) begin
            in_valid3 = 1'b1;
            in_data3  = BW'(base + i);
            @(posedge clk); #1;
            if (i == mark) mark_cyc = cyc;
            in_valid3 = 1'b0;
            done_seen = done3;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (col_out3 !== '0) begin errors++; $display("[TB] FAIL reset_col_out: got %h expected 0", col_out3); end
        checks++; if (col_ptr3 !== 3'b111) begin errors++; $display("[TB] FAIL reset_col_ptr: got %b expected 111", col_ptr3); end
        checks++; if (init3 !== 3'b111) begin errors++; $display("[TB] FAIL reset_init_col_ptr: got %b expected 111", init3); end
        checks++; if (in_ready3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready3); end
        checks++; if (win3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_win_valid: got %b expected 0", win3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy3); end
        checks++; if (done3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", done3); end
        checks++; if (err3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg_err: got %b expected 0", err3); end
        checks++; if (col_ptr5 !== 3'b111) begin errors++; $display("[TB] FAIL reset_k5_col_ptr: got %b expected 111", col_ptr5); end
        checks++; if (col_out5 !== '0) begin errors++; $display("[TB] FAIL reset_k5_col_out: got %h expected 0", col_out5); end
    endtask

    // K=3, 4x3 frame of pixels 1..12; only row 2 emits columns.
    task automatic test_frame_windows(input int gap);
        int mark;
        logic done_seen;
        logic [3*BW-1:0] exp_col;
        clear_mon();
        run_frame3(4, 3, 1, gap, 10, mark, done_seen);
        checks++; if (done_seen !== 1'b1) begin errors++; $display("[TB] FAIL gap%0d_frame_done_after_last: got %b expected 1", gap, done_seen); end
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (win_cnt3 != 2) begin errors++; $display("[TB] FAIL gap%0d_win_count: got %0d expected 2", gap, win_cnt3); end
        checks++; if (first_win3 != mark + 1) begin errors++; $display("[TB] FAIL gap%0d_first_win_cycle: got %0d expected %0d", gap, first_win3, mark + 1); end
        checks++; if (done_cnt3 != 1) begin errors++; $display("[TB] FAIL gap%0d_done_count: got %0d expected 1", gap, done_cnt3); end
        checks++; if (q3_col.size() != 4) begin errors++; $display("[TB] FAIL gap%0d_emit_count: got %0d expected 4", gap, q3_col.size()); end
        for (int i = 0; i < 4 && i < q3_col.size(); i++) begin
            exp_col = {BW'(1 + 8 + i), BW'(1 + 4 + i), BW'(1 + i)};
            checks++; if (q3_ptr[i] !== 3'(i % 3)) begin errors++; $display("[TB] FAIL gap%0d_col_ptr[%0d]: got %0d expected %0d", gap, i, q3_ptr[i], i % 3); end
            checks++; if (q3_init[i] !== 3'((i < 2) ? i : 2)) begin errors++; $display("[TB] FAIL gap%0d_init_ptr[%0d]: got %0d expected %0d", gap, i, q3_init[i], (i < 2) ? i : 2); end
            checks++; if (q3_col[i] !== exp_col) begin errors++; $display("[TB] FAIL gap%0d_col_out[%0d]: got %h expected %h", gap, i, q3_col[i], exp_col); end
        end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("[TB] FAIL gap%0d_busy_after: got %b expected 0", gap, busy3); end
    endtask

    // Rejected configurations: width below K, height below K, width above 2^AW.
    task automatic test_cfg_err();
        int cw[3] = '{2, 4, 257};
        int ch[3] = '{3, 2, 3};
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            img_w3 = (AW+1)'(cw[t]);
            img_h3 = 16'(ch[t]);
            start3 = 1'b1;
            @(posedge clk); #1;
            start3 = 1'b0;
            checks++; if (err3 !== 1'b1) begin errors++; $display("[TB] FAIL cfg%0d_err_pulse: got %b expected 1", t, err3); end
            checks++; if (busy3 !== 1'b0) begin errors++; $display("[TB] FAIL cfg%0d_busy: got %b expected 0", t, busy3); end
            checks++; if (in_ready3 !== 1'b0) begin errors++; $display("[TB] FAIL cfg%0d_in_ready: got %b expected 0", t, in_ready3); end
            @(posedge clk); #1;
            checks++; if (err3 !== 1'b0) begin errors++; $display("[TB] FAIL cfg%0d_err_single: got %b expected 0", t, err3); end
            checks++; if (busy3 !== 1'b0) begin errors++; $display("[TB] FAIL cfg%0d_busy_later: got %b expected 0", t, busy3); end
        end
    endtask

    // K=5, 256x6 frame, pixel (x,y) = (x + 7y) mod 256.
    task automatic test_wide_k5();
        logic done_seen;
        clear_mon();
        done_seen = 1'b0;
        @(posedge clk); #1;
        img_w5 = (AW+1)'(256);
        img_h5 = 16'd6;
        start5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0;
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 256; x++) begin
                in_valid5 = 1'b1;
                in_data5  = BW'((x + 7 * y) & 255);
                @(posedge clk); #1;
                done_seen = done5;
            end
        end
        in_valid5 = 1'b0;
        checks++; if (done_seen !== 1'b1) begin errors++; $display("[TB] FAIL k5_frame_done_after_last: got %b expected 1", done_seen); end
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (win_cnt5 != 504) begin errors++; $display("[TB] FAIL k5_win_count: got %0d expected 504", win_cnt5); end
        checks++; if (q5_col.size() != 512) begin errors++; $display("[TB] FAIL k5_emit_count: got %0d expected 512", q5_col.size()); end
        if (q5_col.size() == 512) begin
            checks++; if (q5_col[0] !== {8'd28, 8'd21, 8'd14, 8'd7, 8'd0}) begin errors++; $display("[TB] FAIL k5_col_first: got %h expected 1c150e0700", q5_col[0]); end
            checks++; if (q5_col[255] !== {8'd27, 8'd20, 8'd13, 8'd6, 8'd255}) begin errors++; $display("[TB] FAIL k5_col_x255: got %h expected 1b140d06ff", q5_col[255]); end
            checks++; if (q5_ptr[255] !== 3'd0) begin errors++; $display("[TB] FAIL k5_ptr_x255: got %0d expected 0", q5_ptr[255]); end
            checks++; if (q5_init[255] !== 3'd4) begin errors++; $display("[TB] FAIL k5_init_x255: got %0d expected 4", q5_init[255]); end
            checks++; if (q5_col[256] !== {8'd35, 8'd28, 8'd21, 8'd14, 8'd7}) begin errors++; $display("[TB] FAIL k5_col_row5_x0: got %h expected 231c150e07", q5_col[256]); end
            checks++; if (q5_ptr[256] !== 3'd0) begin errors++; $display("[TB] FAIL k5_ptr_row5_x0: got %0d expected 0", q5_ptr[256]); end
            checks++; if (q5_init[256] !== 3'd0) begin errors++; $display("[TB] FAIL k5_init_row5_x0: got %0d expected 0", q5_init[256]); end
        end
    endtask

    // Reset in the middle of row 2, then a clean frame with pixels 101..112.
    task automatic test_mid_reset();
        int mark;
        logic done_seen;
        clear_mon();
        @(posedge clk); #1;
        img_w3 = (AW+1)'(4);
        img_h3 = 16'd3;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid3 = 1'b1;
            in_data3  = BW'(1 + i);
            @(posedge clk); #1;
        end
        in_valid3 = 1'b0;
        rstn = 1'b0;
        #1;
        checks++; if (col_out3 !== '0) begin errors++; $display("[TB] FAIL midrst_col_out: got %h expected 0", col_out3); end
        checks++; if (col_ptr3 !== 3'b111) begin errors++; $display("[TB] FAIL midrst_col_ptr: got %b expected 111", col_ptr3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy3); end
        checks++; if (in_ready3 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_in_ready: got %b expected 0", in_ready3); end
        @(posedge clk); #1;
        rstn = 1'b1;
        checks++; if (done_cnt3 != 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", done_cnt3); end
        clear_mon();
        run_frame3(4, 3, 101, 0, 10, mark, done_seen);
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (win_cnt3 != 2) begin errors++; $display("[TB] FAIL midrst_win_count: got %0d expected 2", win_cnt3); end
        checks++; if (done_cnt3 != 1) begin errors++; $display("[TB] FAIL midrst_done_count: got %0d expected 1", done_cnt3); end
        checks++; if (q3_col.size() < 1 || q3_col[0] !== {8'd109, 8'd105, 8'd101}) begin errors++; $display("[TB] FAIL midrst_first_col: got %h expected 6d6965", (q3_col.size() > 0) ? q3_col[0] : '0); end
        checks++; if (q3_col.size() < 4 || q3_col[3] !== {8'd112, 8'd108, 8'd104}) begin errors++; $display("[TB] FAIL midrst_last_col: got %h expected 706c68", (q3_col.size() > 3) ? q3_col[3] : '0); end
    endtask

    // start while busy and in the DONE cycle must be ignored; in IDLE it is taken.
    task automatic test_start_ignored();
        clear_mon();
        @(posedge clk); #1;
        img_w3 = (AW+1)'(4);
        img_h3 = 16'd3;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid3 = 1'b1;
            in_data3  = BW'(1 + i);
            if (i == 5) begin start3 = 1'b1; img_w3 = (AW+1)'(2); end
            if (i == 7) begin start3 = 1'b1; img_w3 = (AW+1)'(5); img_h3 = 16'd5; end
            @(posedge clk); #1;
            start3 = 1'b0;
            if (i == 6) begin
                checks++; if (err3 !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_err: got %b expected 0", err3); end
            end
        end
        in_valid3 = 1'b0;
        checks++; if (done3 !== 1'b1) begin errors++; $display("[TB] FAIL busy_start_done: got %b expected 1", done3); end
        img_w3 = (AW+1)'(4);
        img_h3 = 16'd3;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        checks++; if (busy3 !== 1'b0) begin errors++; $display("[TB] FAIL done_start_busy: got %b expected 0", busy3); end
        checks++; if (in_ready3 !== 1'b0) begin errors++; $display("[TB] FAIL done_start_in_ready: got %b expected 0", in_ready3); end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (win_cnt3 != 2) begin errors++; $display("[TB] FAIL busy_start_win_count: got %0d expected 2", win_cnt3); end
        checks++; if (q3_col.size() < 1 || q3_col[0] !== {8'd9, 8'd5, 8'd1}) begin errors++; $display("[TB] FAIL busy_start_first_col: got %h expected 090501", (q3_col.size() > 0) ? q3_col[0] : '0); end
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        checks++; if (busy3 !== 1'b1) begin errors++; $display("[TB] FAIL idle_start_busy: got %b expected 1", busy3); end
        checks++; if (in_ready3 !== 1'b1) begin errors++; $display("[TB] FAIL idle_start_in_ready: got %b expected 1", in_ready3); end
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    // Sequence of scenarios followed by the summary line.
    initial begin
        #2 rstn = 1'b0;
        #20;
        test_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        test_frame_windows(0);
        test_frame_windows(3);
        test_cfg_err();
        test_wide_k5();
        test_mid_reset();
        test_start_ignored();
        repeat (2) begin @(posedge clk); #1; end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on total run time so the bench never hangs.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/line_buffer_col_feeder.md
Name: line_buffer_col_feeder

Overview:
- Producer side of the KxK window register array. It accepts a raster pixel stream (one pixel per handshake) and keeps KER_SIZE-1 previous image rows in internal row storage.
- For each accepted pixel it drives one KER_SIZE-tall pixel column, plus the col_ptr / init_col_ptr pointers that the window array consumes.
- It also flags the cycle in which the downstream window output becomes a valid KxK window.
- It sits between the input activation stream and the window array inside the convolution datapath.

Parameters:
- KER_SIZE, 3, kernel height/width; legal range 2..5, which fits the 3-bit pointer encoding.
- BITWIDTH, 8, bits per pixel.
- AW, 8, column address width; maximum image width is 2^AW.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle frame start pulse.
- img_w  in  AW+1  frame width in pixels; latched on an accepted start.
- img_h  in  16  frame height in rows; latched on an accepted start.
- in_valid  in  1  input pixel valid.
- in_data  in  BITWIDTH  input pixel.
- in_ready  out  1  feeder can accept a pixel.
- col_out  out  BITWIDTH*KER_SIZE  pixel column. Slice k covers bits [BITWIDTH*(k+1)-1 : BITWIDTH*k]; slice 0 is the oldest (top) row and slice KER_SIZE-1 is the current row.
- col_ptr  out  3  circular column slot for col_out; 3'b111 means idle.
- init_col_ptr  out  3  columns-filled indicator for the current row; 3'b111 means idle.
- win_valid  out  1  the window array output holds a valid window this cycle.
- busy  out  1  a frame is in progress.
- frame_done  out  1  single-cycle pulse after the last pixel of the frame is accepted.
- cfg_err  out  1  single-cycle pulse when a start is rejected.

Behaviour:
Reset:
- All state is cleared asynchronously, including the row storage.
- Output reset values: col_out=0, col_ptr=3'b111, init_col_ptr=3'b111, in_ready=0, win_valid=0, busy=0, frame_done=0, cfg_err=0.
- Reset asserted mid-frame aborts the frame immediately; no frame_done is produced.

FSM states: IDLE, FILL, STREAM, DONE.
- IDLE:
  - start with KER_SIZE <= img_w <= 2^AW and KER_SIZE <= img_h: latch the config, clear col_x and row_y, go to FILL (or to STREAM directly when KER_SIZE==1 is not legal, so always FILL).
  - start with out-of-range config: pulse cfg_err the next cycle and stay in IDLE.
- FILL: rows 0..KER_SIZE-2. When the last pixel of row KER_SIZE-2 is accepted, go to STREAM.
- STREAM: rows KER_SIZE-1..img_h-1. When the pixel at (img_w-1, img_h-1) is accepted, go to DONE.
- DONE: one cycle; frame_done=1; return to IDLE.
- busy=1 in FILL and STREAM.
- start is ignored outside IDLE.

Handshake:
- in_ready = 1 in FILL and STREAM, 0 in IDLE and DONE.
- A pixel is accepted when in_valid & in_ready.
- The feeder never stalls within a frame, because the array has no backpressure.

Counters:
- col_x runs 0..img_w-1 and wraps to 0 at end of row, incrementing row_y.
- cslot runs 0..KER_SIZE-1 and wraps; it resets to 0 at every row start.

Row storage:
- lb[j][x] for j = 0..KER_SIZE-2, x < 2^AW; lb[0] is the oldest row.
- On acceptance at column x: lb[j][x] <= lb[j+1][x] for j < KER_SIZE-2, and lb[KER_SIZE-2][x] <= in_data.

Column emit (STREAM acceptances only, registered, 1-cycle latency):
- col_out <= {in_data, lb[KER_SIZE-2][x], ..., lb[0][x]}, using the pre-update contents.
- col_ptr <= cslot.
- init_col_ptr <= min(col_x, KER_SIZE-1).
- In all other cycles (no acceptance, FILL, IDLE, DONE): col_ptr and init_col_ptr are 3'b111 and col_out holds its last value. The array therefore writes no slot and holds its output.

win_valid:
- Registered from (emit & col_x >= KER_SIZE-1).
- A pixel accepted in cycle t gives col_out in cycle t+1 and win_valid in cycle t+2, aligned with the array output.

Window count:
- A frame produces (img_w-KER_SIZE+1) * (img_h-KER_SIZE+1) win_valid pulses.
- Row boundaries never produce a window that mixes two rows: init_col_ptr restarts at 0 at every row start.

Test Plan:
1. K=3, img_w=4, img_h=3, pixel values 1..12 streamed back-to-back -> exactly 2 win_valid pulses. The first is 2 cycles after pixel 11 is accepted; the col_out for pixel 9 is {9,5,1}; col_ptr follows 0,1,2,0 on row 2; init_col_ptr follows 0,1,2,2.
2. Same frame with in_valid gaps of 3 cycles -> col_ptr/init_col_ptr are 3'b111 during the gaps; the win_valid count and the windows are identical to scenario 1.
3. start with img_w=2 (< K=3) -> cfg_err pulses once, busy stays 0, in_ready stays 0.
4. K=5, img_w=256, img_h=6 -> col_x wraps cleanly at 255; 504 win_valid pulses; frame_done fires 1 cycle after the last acceptance.
5. rstn asserted mid-row of STREAM -> all outputs take their reset values immediately; a following new frame produces correct windows with zero-filled history and no stale data.
6. start asserted during busy, and again in the DONE cycle -> both ignored; the next start in IDLE is accepted.
